wb_ram_ctrl: RTL
================

# wb_ram_ctrl

Parametrised Wishbone single-port RAM slave that generalises the basic RAM wrapper: configurable word width, depth and base address, byte-lane writes via `wb_sel`, programmable wait states, and a registered acknowledge FSM with abort handling. Used for instruction/data scratchpads on the system Wishbone crossbar. The RAM array is inferred internally.

## Interface
- `DEPTH`, 1024: number of words; power of two, ≥ 2.
- `WORD_WIDTH`, 32: data width in bits; multiple of 8 (8, 16, 32, 64).
- `ADDR_WIDTH`, 32: width of `wb_adr`.
- `BASE_ADDR`, 0: byte base address; aligned to `DEPTH*WORD_WIDTH/8`.
- `WAIT_STATES`, 0: extra cycles between request capture and ack; 0–15.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `wb_bus`  `wb_bus_t.slave`  —  Wishbone slave port. Inputs: `wb_cyc`, `wb_stb`, `wb_we`, `wb_adr[ADDR_WIDTH]`, `wb_dat_ms[WORD_WIDTH]`, `wb_sel[WORD_WIDTH/8]`. Outputs: `wb_dat_sm[WORD_WIDTH]`, `wb_ack`, `wb_err`, `wb_rty`, `wb_tgd_sm`.

## Operation
- Request is `wb_cyc & wb_stb`. Word index is `wb_adr[ADDR_LSB +: $clog2(DEPTH)]`, where `ADDR_LSB = $clog2(WORD_WIDTH/8)`. Low address bits are ignored.
- FSM states: `IDLE`, `WAIT`, `RESP`.
  - `IDLE` with request: latch `adr`, `we`, `dat_ms` and `sel`; load the wait counter with `WAIT_STATES`. Go to `WAIT` if `WAIT_STATES>0`, else go to `RESP`.
  - `WAIT`: decrement the counter each cycle. At 1 → `RESP`. If `wb_cyc` drops → `IDLE`; no response, no write.
  - `RESP`: assert exactly one of `wb_ack` or `wb_err` for exactly one cycle, then → `IDLE` unconditionally.
- Commit happens at the edge entering `RESP`.
  - Write: for each lane i with `sel[i]=1`, `mem[idx][8i+:8] <= dat[8i+:8]`; other lanes are unchanged.
  - Read: `wb_dat_sm <= mem[idx]`.
- `wb_dat_sm` holds its value until the next read commit. Writes do not alter it.
- `wb_sel=0` on a write: acked, memory unchanged.
- `wb_rty` and `wb_tgd_sm` are tied to 0.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `wb_ack=0`, `wb_err=0`, `wb_dat_sm=0`, FSM=`IDLE`, counter=0.
- Latency: request sampled at edge N → response high in cycle N+1+`WAIT_STATES`. Minimum is 1 cycle.
- Throughput: one transfer per 2+`WAIT_STATES` cycles. The response is never high on two consecutive cycles. A request still held during `RESP` is ignored; the master must deassert `stb` on seeing ack.
- Reset asserted in any state: FSM → `IDLE` and outputs go to reset values immediately. A write not yet committed is dropped; a committed write persists.
- `wb_cyc` deasserted in `RESP`: the response pulse still completes.
- Read-after-write to the same address in the next transaction returns the new data.

## Configuration
- `WB_RAM_CTRL_RANGE_CHECK_EN` defined:
  - The latched byte address is compared against [`BASE_ADDR`, `BASE_ADDR + DEPTH*WORD_WIDTH/8`).
  - An out-of-range request gets `wb_err` instead of `wb_ack` in `RESP`, with identical latency.
  - No write is performed and `wb_dat_sm` is unchanged.
- Not defined: no comparison. All addresses alias modulo depth, and `wb_err` is tied to 0.

## Test plan
1. Reset, `WAIT_STATES=0`: write 0xDEADBEEF to 0x10 with sel=0xF → ack 1 cycle after request; read 0x10 → ack after 1 cycle, `wb_dat_sm=0xDEADBEEF`.
2. Byte lanes: preload 0x11223344 at 0x20; write 0xAABBCCDD with sel=0b0101; read → 0x11BB33DD.
3. `WAIT_STATES=3`: read request at edge N → ack high only in cycle N+4, single cycle. Hold `stb` through ack → next ack not before N+6.
4. Abort: `WAIT_STATES=3`, write 0x55 to 0x30, drop `wb_cyc` after 1 cycle → no ack; read 0x30 returns the prior value.
5. Range check enabled, `BASE_ADDR=0x1000`, `DEPTH=1024`, 32-bit: access 0x2000 → `wb_err` pulse, `wb_ack=0`, memory unchanged. Disabled: same access → ack, aliases to word 0.
6. Assert `rstn_i` mid-`WAIT` → `wb_ack=0`, FSM `IDLE`. After release, a new read completes normally.

Source files
------------

// File: rtl/wb_ram_ctrl_if.sv
// wb_bus_t: Wishbone classic bus bundle between a master and a RAM slave.
// Slave drives read data, response strobes and the tied-off rty/tgd lines.
interface wb_bus_t #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_WIDTH = 32
);
  logic                    wb_cyc;
  logic                    wb_stb;
  logic                    wb_we;
  logic [ADDR_WIDTH-1:0]   wb_adr;
  logic [WORD_WIDTH-1:0]   wb_dat_ms;
  logic [WORD_WIDTH/8-1:0] wb_sel;
  logic [WORD_WIDTH-1:0]   wb_dat_sm;
  logic                    wb_ack;
  logic                    wb_err;
  logic                    wb_rty;
  logic                    wb_tgd_sm;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
    input  wb_dat_sm, wb_ack, wb_err, wb_rty, wb_tgd_sm
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
    output wb_dat_sm, wb_ack, wb_err, wb_rty, wb_tgd_sm
  );
endinterface

// File: rtl/wb_ram_ctrl.sv
// wb_ram_ctrl: Wishbone RAM slave, byte lanes, wait states, abort handling.
// Define WB_RAM_CTRL_RANGE_CHECK_EN to answer out-of-window accesses with err.
module wb_ram_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic    clk,
  input logic    rstn_i,
  wb_bus_t.slave wb_bus
);
  localparam int NSEL     = int'(WORD_WIDTH / 8);
  localparam int ADDR_LSB = $clog2(NSEL);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SIZE =
    (ADDR_WIDTH+1)'(DEPTH * WORD_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic                  we_q;
  logic [WORD_WIDTH-1:0] dat_q;
  logic [NSEL-1:0]       sel_q;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic                  ack_q;
  logic                  err_q;

  logic [WORD_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_adr;
  logic                  c_we;
  logic [WORD_WIDTH-1:0] c_dat;
  logic [NSEL-1:0]       c_sel;
  logic [IDX_W-1:0]      c_idx;
  logic                  c_ok;

  assign req = wb_bus.wb_cyc & wb_bus.wb_stb;

  // Zero wait states commit on the capture edge, straight from the bus.
  assign c_adr = (state == IDLE) ? wb_bus.wb_adr    : adr_q;
  assign c_we  = (state == IDLE) ? wb_bus.wb_we     : we_q;
  assign c_dat = (state == IDLE) ? wb_bus.wb_dat_ms : dat_q;
  assign c_sel = (state == IDLE) ? wb_bus.wb_sel    : sel_q;
  assign c_idx = c_adr[ADDR_LSB +: IDX_W];

  assign commit = rstn_i && (
    (state == IDLE && req && WAIT_STATES == 0) ||
    (state == WAIT && wb_bus.wb_cyc && cnt == 4'd1));

`ifdef WB_RAM_CTRL_RANGE_CHECK_EN
  logic [ADDR_WIDTH:0] off;
  assign off  = {1'b0, c_adr} - {1'b0, BASE_ADDR};
  assign c_ok = !off[ADDR_WIDTH] && (off < SIZE);
`else
  assign c_ok = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{c_adr, SIZE, BASE_ADDR};

  always_ff @(posedge clk) begin
    if (commit && c_we && c_ok) begin
      for (int i = 0; i < NSEL; i++) begin
        if (c_sel[i]) mem[c_idx][8*i +: 8] <= c_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      cnt     <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (commit) begin
        ack_q <= c_ok;
        err_q <= !c_ok;
        if (!c_we && c_ok) rdata_q <= mem[c_idx];
      end
      unique case (state)
        IDLE: begin
          if (req) begin
            adr_q <= wb_bus.wb_adr;
            we_q  <= wb_bus.wb_we;
            dat_q <= wb_bus.wb_dat_ms;
            sel_q <= wb_bus.wb_sel;
            cnt   <= 4'(WAIT_STATES);
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!wb_bus.wb_cyc) state <= IDLE;
          else if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_bus.wb_dat_sm = rdata_q;
  assign wb_bus.wb_ack    = ack_q;
  assign wb_bus.wb_err    = err_q;
  assign wb_bus.wb_rty    = 1'b0;
  assign wb_bus.wb_tgd_sm = 1'b0;
endmodule
